pc_sequencer: RTL
=================

# pc_sequencer

Controls next-PC selection for the five-stage processor. Each cycle it supplies the write-enable and next value for the falling-edge program counter register, chosen from sequential increment, branch or jump redirect, exception vector, or hold. A small state machine covers boot, normal run, mult/div wait and halt, and generates the pipeline flush for redirects. The PC register's read enable is tied high, and its output feeds back as `pc_cur`.

## Interface
- `RESET_PC`, default 32'd0: PC loaded on boot.
- `EXC_PC`, default 32'd4096: exception handler address.
- `MD_TIMEOUT`, default 64: maximum cycles allowed in MD_WAIT (used only under `PC_SEQ_MD_TIMEOUT_EN`).
- `clk`  in  1  system clock; state updates on the rising edge.
- `clr`  in  1  reset, synchronous and active-high.
- `pc_cur`  in  32  current PC register output.
- `stall`  in  1  load-use hazard; hold PC.
- `md_start`  in  1  mult/div issued this cycle.
- `md_ready`  in  1  mult/div result valid.
- `br_taken`  in  1  branch resolved taken in X.
- `br_target`  in  32  branch target.
- `jmp`  in  1  j/jal/jr resolved in X.
- `jmp_target`  in  32  jump target.
- `exc`  in  1  exception raised.
- `halt`  in  1  halt instruction reached X.
- `pc_next`  out  32  value written to the PC register.
- `pc_w_en`  out  1  PC register write enable.
- `flush`  out  1  squash F/D and D/X latches.
- `epc`  out  32  PC captured at the last exception.
- `md_abort`  out  1  one-cycle pulse on mult/div timeout.
- `state`  out  2  BOOT=0, RUN=1, MD_WAIT=2, HALTED=3.

## Operation
- `state` and `epc` are registered. The timeout counter is registered. `pc_next`, `pc_w_en`, `flush` and `md_abort` are combinational from state and inputs.
- **Reset:** while `clr` is sampled high, the next state is BOOT and `epc` becomes 0. BOOT outputs are `pc_w_en`=1, `pc_next`=`RESET_PC`, `flush`=1 and `md_abort`=0. BOOT always advances to RUN.
- **RUN** evaluates the following in priority order:
  1. `exc`: write `EXC_PC`, `flush`=1, `epc`<=`pc_cur`.
  2. `br_taken`: write `br_target`, `flush`=1.
  3. `jmp`: write `jmp_target`, `flush`=1.
  4. `halt`: `pc_w_en`=0, go to HALTED.
  5. `md_start`: `pc_w_en`=0, go to MD_WAIT, clear the counter.
  6. `stall`: `pc_w_en`=0.
  7. Otherwise write `pc_cur`+1. The address is word-granular and wraps modulo 2^32, so 32'hFFFFFFFF goes to 0.
- Redirects (1–3) override `stall`, because the stalled instruction is squashed.
- **MD_WAIT** holds with `pc_w_en`=0 and ignores `stall`, `br_taken`, `jmp` and `halt`.
  - On `md_ready`: write `pc_cur`+1 and return to RUN.
  - On `exc` (wins over `md_ready`): write `EXC_PC`, `flush`=1, `epc`<=`pc_cur`, return to RUN.
- **HALTED:** `pc_w_en`=0, `flush`=0. All inputs are ignored, including `exc`. Only `clr` leaves this state.
- `flush` is 0 whenever `pc_w_en`=0 or the write is sequential.

## Timing
- Outputs settle after the rising edge. The PC register samples them on the following falling edge, so a redirect seen in cycle N takes effect in PC half a cycle later.
- The first fetch after `clr` deasserts is from `RESET_PC`. That PC is written in the BOOT cycle, one cycle after reset is released.
- `clr` asserted mid-MD_WAIT or in HALTED returns the block to BOOT on the next rising edge. The counter and `epc` clear.
- `md_start` together with `md_ready` in the same RUN cycle: `md_start` wins and the block enters MD_WAIT. `md_ready` is not latched.

## Configuration
- **`PC_SEQ_MD_TIMEOUT_EN` defined:**
  - An 8-bit counter increments each MD_WAIT cycle.
  - When it reaches `MD_TIMEOUT` without `md_ready`, the block pulses `md_abort`=1, writes `EXC_PC`, asserts `flush`, sets `epc`<=`pc_cur` and returns to RUN.
  - If `md_ready` arrives on the timeout cycle, `md_ready` wins.
- **Undefined:** no counter is built, `md_abort` is tied to 0, and MD_WAIT waits indefinitely.

## Test plan
- **Reset:** `clr` high for 2 cycles, then low. Expect BOOT with `pc_w_en`=1, `pc_next`=0, `flush`=1; then RUN with `pc_next`=`pc_cur`+1. Check `pc_cur`=32'hFFFFFFFF gives `pc_next`=0.
- **Priority:** in RUN, assert `exc`, `br_taken` (target 0x40) and `stall` together with `pc_cur`=0x10. Expect `pc_next`=4096, `flush`=1, and `epc`=0x10 next cycle. Drop `exc`: expect `pc_next`=0x40.
- **Stall:** `stall`=1 for 3 cycles. Expect `pc_w_en`=0 and `flush`=0 throughout. Add `jmp` (target 0x80) in cycle 2. Expect `pc_w_en`=1, `pc_next`=0x80, `flush`=1.
- **Mult/div:** `md_start` at `pc_cur`=0x20. Expect `state`=2 and `pc_w_en`=0 for 5 cycles while `br_taken` toggles. Then `md_ready` gives `pc_next`=0x21 and `state`=1.
- **Timeout:** with `PC_SEQ_MD_TIMEOUT_EN` and `MD_TIMEOUT`=4, no `md_ready` after `md_start`. Expect a `md_abort` pulse on the 4th MD_WAIT cycle with `pc_next`=4096. Without the macro, expect MD_WAIT held for 100 cycles.
- **Halt:** `halt` gives `state`=3 and `pc_w_en`=0, and `exc` has no effect. Asserting `clr` returns to BOOT with `pc_next`=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the pipeline/PC register.
// master = sequencer side, slave = pipeline side.
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic        stall;
    logic        md_start;
    logic        md_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        halt;
    logic [31:0] pc_next;
    logic        pc_w_en;
    logic        flush;
    logic [31:0] epc;
    logic        md_abort;
    logic [1:0]  state;

    // pc_w_en is a single-cycle write strobe with no back-pressure: the PC
    // register captures pc_next on the falling edge of every cycle it is high.
    modport master (
        input  pc_cur, stall, md_start, md_ready, br_taken, br_target,
               jmp, jmp_target, exc, halt,
        output pc_next, pc_w_en, flush, epc, md_abort, state
    );

    modport slave (
        output pc_cur, stall, md_start, md_ready, br_taken, br_target,
               jmp, jmp_target, exc, halt,
        input  pc_next, pc_w_en, flush, epc, md_abort, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and boot/run/mult-div/halt control for the falling-edge PC register.
// Optional mult/div watchdog is built when PC_SEQ_MD_TIMEOUT_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] EXC_PC     = 32'd4096,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           clr,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MD_WAIT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic        pc_w_en;
    logic        flush;
    logic        md_abort;

`ifdef PC_SEQ_MD_TIMEOUT_EN
    localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       md_expired;
    // Counter holds cycles already spent in MD_WAIT, so this cycle is the last allowed one.
    assign md_expired = (cnt_q == MD_LAST);
`endif

    assign pc_seq = bus.pc_cur + 32'd1;

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        pc_next  = pc_seq;
        pc_w_en  = 1'b0;
        flush    = 1'b0;
        md_abort = 1'b0;
`ifdef PC_SEQ_MD_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            BOOT: begin
                pc_w_en = 1'b1;
                pc_next = RESET_PC;
                flush   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // Redirects outrank stall: the stalled instruction is squashed anyway.
                if (bus.exc) begin
                    pc_w_en = 1'b1;
                    pc_next = EXC_PC;
                    flush   = 1'b1;
                    epc_d   = bus.pc_cur;
                end else if (bus.br_taken) begin
                    pc_w_en = 1'b1;
                    pc_next = bus.br_target;
                    flush   = 1'b1;
                end else if (bus.jmp) begin
                    pc_w_en = 1'b1;
                    pc_next = bus.jmp_target;
                    flush   = 1'b1;
                end else if (bus.halt) begin
                    state_d = HALTED;
                end else if (bus.md_start) begin
                    state_d = MD_WAIT;
`ifdef PC_SEQ_MD_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else if (!bus.stall) begin
                    pc_w_en = 1'b1;
                end
            end
            MD_WAIT: begin
`ifdef PC_SEQ_MD_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (bus.exc) begin
                    pc_w_en = 1'b1;
                    pc_next = EXC_PC;
                    flush   = 1'b1;
                    epc_d   = bus.pc_cur;
                    state_d = RUN;
                end else if (bus.md_ready) begin
                    pc_w_en = 1'b1;
                    state_d = RUN;
                end
`ifdef PC_SEQ_MD_TIMEOUT_EN
                else if (md_expired) begin
                    md_abort = 1'b1;
                    pc_w_en  = 1'b1;
                    pc_next  = EXC_PC;
                    flush    = 1'b1;
                    epc_d    = bus.pc_cur;
                    state_d  = RUN;
                end
`endif
            end
            HALTED: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= BOOT;
            epc_q   <= 32'd0;
`ifdef PC_SEQ_MD_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
`ifdef PC_SEQ_MD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.pc_next  = pc_next;
    assign bus.pc_w_en  = pc_w_en;
    assign bus.flush    = flush;
    assign bus.md_abort = md_abort;
    assign bus.epc      = epc_q;
    assign bus.state    = state_q;
endmodule
